plab4_net_domain_link_sched: RTL



---
 rtl/plab4_net_domain_link_sched.sv | 115 +++++++++++
 1 files changed

// File: rtl/plab4_net_domain_link_sched.sv
// Fixed-slot TDM scheduler sharing one ring link between domains D1 and D2, with a one-entry output register.
// Optional build macro: PLAB4_NET_SCHED_WORK_CONSERVING_EN (idle owner yields its slot early; not timing-noninterfering).
module plab4_net_domain_link_sched #(
  parameter int p_msg_cnbits  = 32,
  parameter int p_msg_dnbits  = 32,
  parameter int p_slot_cycles = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_val_d1,
  output logic                             in_rdy_d1,
  input  logic [p_msg_cnbits-1:0]          in_msg_control_d1,
  input  logic [p_msg_dnbits-1:0]          in_msg_data_d1,
  input  logic                             in_val_d2,
  output logic                             in_rdy_d2,
  input  logic [p_msg_cnbits-1:0]          in_msg_control_d2,
  input  logic [p_msg_dnbits-1:0]          in_msg_data_d2,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [p_msg_cnbits-1:0]          out_msg_control,
  output logic [p_msg_dnbits-1:0]          out_msg_data,
  output logic                             out_domain,
  output logic                             slot_owner,
  output logic                             o_dbg_state,
  output logic [$clog2(p_slot_cycles)-1:0] o_dbg_cnt
);

  localparam int CW = $clog2(p_slot_cycles);
  localparam logic [CW-1:0] LAST = CW'(p_slot_cycles - 1);

  typedef enum logic {
    SLOT_D1 = 1'b0,
    SLOT_D2 = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_next;
  logic                    r_out_val;
  logic [p_msg_cnbits-1:0] r_out_ctl;
  logic [p_msg_dnbits-1:0] r_out_data;
  logic                    r_out_dom;
  logic                    w_guard;
  logic                    w_free;
  logic                    w_xfer_d1;
  logic                    w_xfer_d2;

  // Handshake: a transfer on input X happens when in_val_dX && in_rdy_dX at the clock edge;
  // the output entry drains when out_val && out_rdy. in_rdy never looks at either in_val.
  assign w_guard   = (r_cnt == LAST);
  assign w_free    = !r_out_val || out_rdy;
  assign in_rdy_d1 = reset && (r_state == SLOT_D1) && !w_guard && w_free;
  assign in_rdy_d2 = reset && (r_state == SLOT_D2) && !w_guard && w_free;
  assign w_xfer_d1 = in_val_d1 && in_rdy_d1;
  assign w_xfer_d2 = in_val_d2 && in_rdy_d2;

`ifdef PLAB4_NET_SCHED_WORK_CONSERVING_EN
  logic w_own_idle;
  logic w_other_val;
  assign w_own_idle  = (r_state == SLOT_D1) ? !in_val_d1 : !in_val_d2;
  assign w_other_val = (r_state == SLOT_D1) ? in_val_d2 : in_val_d1;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    if (w_guard) begin
      w_cnt_next   = '0;
      w_state_next = (r_state == SLOT_D1) ? SLOT_D2 : SLOT_D1;
    end
`ifdef PLAB4_NET_SCHED_WORK_CONSERVING_EN
    else if (w_own_idle && w_other_val) begin
      w_cnt_next   = '0;
      w_state_next = (r_state == SLOT_D1) ? SLOT_D2 : SLOT_D1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SLOT_D1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A load and a drain in the same cycle simply overwrite the entry, sustaining one message per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_val  <= 1'b0;
      r_out_ctl  <= '0;
      r_out_data <= '0;
      r_out_dom  <= 1'b0;
    end else if (w_xfer_d1 || w_xfer_d2) begin
      r_out_val  <= 1'b1;
      r_out_ctl  <= w_xfer_d2 ? in_msg_control_d2 : in_msg_control_d1;
      r_out_data <= w_xfer_d2 ? in_msg_data_d2 : in_msg_data_d1;
      r_out_dom  <= w_xfer_d2;
    end else if (r_out_val && out_rdy) begin
      r_out_val <= 1'b0;
    end
  end

  assign out_val         = r_out_val;
  assign out_msg_control = r_out_ctl;
  assign out_msg_data    = r_out_data;
  assign out_domain      = r_out_dom;
  assign slot_owner      = r_state;
  assign o_dbg_state     = r_state;
  assign o_dbg_cnt       = r_cnt;

endmodule
